alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the 16-bit CPU ALU.
- Adds a valid/ready handshake, signed flags, arithmetic shift, unsigned compare, and iterative multi-cycle multiply/divide/remainder.
- Sits in the execute stage of the RISC CPU; the control unit stalls on in_ready low.
- All results are registered and presented with a one-cycle out_valid pulse.

Parameters:
- WIDTH, 16, operand/result width in bits (≥4, power of two).
- SHW, $clog2(WIDTH), shift-amount bits taken from i2[SHW-1:0] (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/op present this cycle.
- in_ready  output  1  block idle and able to accept.
- op  input  4  operation select.
- i1  input  WIDTH  operand A.
- i2  input  WIDTH  operand B.
- out_valid  output  1  one-cycle pulse; result/flags valid.
- o1  output  WIDTH  result.
- zero  output  1  o1 == 0.
- ovf  output  1  signed overflow (ADD/SUB only; else 0).
- dz  output  1  divide by zero (DIVU/REMU with i2 == 0).
- bad_op  output  1  unsupported op code.

Behaviour:
- Op encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLL, 0101 SRL, 0110 SLT (signed), 0111 NOR.
  - 1000 SRA, 1001 SLTU, 1010 MUL (low WIDTH bits of unsigned product), 1011 MULHU (high WIDTH bits), 1100 DIVU, 1101 REMU.
  - 1110, 1111 are invalid.
- Shifts use i2[SHW-1:0] only; upper bits of i2 are ignored.
- SLT/SLTU produce 1 or 0, zero-extended to WIDTH.
- ovf: ADD sets it when the operands have the same sign and the result sign differs; SUB sets it when the operands have different signs and the result sign differs from i1.
- Reset: state IDLE, in_ready = 1, out_valid = 0, o1 = 0, zero = 0, ovf = 0, dz = 0, bad_op = 0. Reset overrides everything, including a multiply/divide in flight: it is aborted and no out_valid is issued.
- Handshake:
  - Accept occurs on a rising edge with in_valid & in_ready; operands and op are latched at that edge.
  - in_ready = 1 only in IDLE. in_valid while not ready is ignored; the caller must hold its request.
- States:
  - IDLE:
    - On accept with a single-cycle op (0000–1001), an invalid op, or DIVU/REMU with i2 == 0: go to DONE.
    - On accept with MUL/MULHU: go to MUL (counter = WIDTH).
    - On accept with DIVU/REMU and i2 ≠ 0: go to DIV (counter = WIDTH).
  - MUL: shift-add, one multiplier bit per cycle into a 2·WIDTH accumulator. Decrement counter; at 0 go to DONE.
  - DIV: restoring division, one quotient bit per cycle (remainder WIDTH+1 bits). Decrement counter; at 0 go to DONE.
  - DONE: out_valid = 1 for exactly one cycle with o1 and flags, then go to IDLE. in_ready = 0 in DONE, so back-to-back accepts are spaced 2 cycles apart for single-cycle ops.
- Latency (accept edge to out_valid high):
  - Single-cycle, invalid, and divide-by-zero ops: 1 cycle.
  - MUL/MULHU/DIVU/REMU: WIDTH+1 cycles.
- Outputs hold their values after out_valid drops, until the next DONE or reset.
- Divide by zero: DIVU gives o1 = all ones; REMU gives o1 = i1; dz = 1.
- bad_op = 1 with o1 = 0 for op 1110/1111.
- zero is computed from the registered o1 in all cases.
- Flags not applicable to the current op are driven 0.

Test Plan:
- Reset, then ADD i1=0x7FFF, i2=0x0001 -> out_valid 1 cycle after accept; o1=0x8000, ovf=1, zero=0.
- SUB 0x1234-0x1234, then SRA 0x8000 by i2=0x0013 (shift 3) -> o1=0x0000, zero=1; then o1=0xF000.
- SLT 0xFFFF vs 0x0001 -> o1=1; SLTU with the same operands -> o1=0.
- MUL 0x0123×0x0456 -> out_valid exactly 17 cycles after accept, o1=0xEDC2; MULHU with the same operands -> o1=0x0004; in_ready low throughout the operation.
- DIVU 1000/7 -> o1=142 after 17 cycles; REMU -> o1=6; DIVU 5/0 -> o1=0xFFFF, dz=1, latency 1.
- Assert reset mid-MUL (cycle 8) -> no out_valid; outputs 0, in_ready=1 next cycle. Op 1111 -> bad_op=1, o1=0. in_valid held during busy -> accepted only once idle.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Registered ALU with valid/ready handshake and iterative
//               shift-add multiply and restoring divide/remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    output logic             out_valid,
    output logic [WIDTH-1:0] o1,
    output logic             zero,
    output logic             ovf,
    output logic             dz,
    output logic             bad_op
);

    localparam int c_CNT_W = SHW + 1;
    localparam int c_MSB   = WIDTH - 1;

    localparam logic [3:0] c_OP_ADD   = 4'h0;
    localparam logic [3:0] c_OP_SUB   = 4'h1;
    localparam logic [3:0] c_OP_AND   = 4'h2;
    localparam logic [3:0] c_OP_OR    = 4'h3;
    localparam logic [3:0] c_OP_SLL   = 4'h4;
    localparam logic [3:0] c_OP_SRL   = 4'h5;
    localparam logic [3:0] c_OP_SLT   = 4'h6;
    localparam logic [3:0] c_OP_NOR   = 4'h7;
    localparam logic [3:0] c_OP_SRA   = 4'h8;
    localparam logic [3:0] c_OP_SLTU  = 4'h9;
    localparam logic [3:0] c_OP_MUL   = 4'hA;
    localparam logic [3:0] c_OP_MULHU = 4'hB;
    localparam logic [3:0] c_OP_DIVU  = 4'hC;
    localparam logic [3:0] c_OP_REMU  = 4'hD;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MUL  = 2'd1;
    localparam logic [1:0] c_ST_DIV  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;

    logic [WIDTH-1:0]   r_o1;
    logic               r_zero;
    logic               r_ovf;
    logic               r_dz;
    logic               r_bad;
    logic               r_valid;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_add;
    logic [WIDTH-1:0]   w_sub;
    logic [SHW-1:0]     w_sh;
    logic [WIDTH-1:0]   w_res;
    logic               w_ovf;
    logic               w_dz;
    logic               w_bad;

    assign in_ready  = (r_state == c_ST_IDLE);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_cnt == c_CNT_W'(1));

    assign out_valid = r_valid;
    assign o1        = r_o1;
    assign zero      = r_zero;
    assign ovf       = r_ovf;
    assign dz        = r_dz;
    assign bad_op    = r_bad;

    // Multiply step: add multiplicand into the high half when the current
    // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
    assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});

    // Restoring divide step; the true difference always fits in WIDTH bits
    // when it is non-negative, so the truncated subtraction is exact.
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_b});
    assign w_diff   = w_rem_sh[WIDTH-1:0] - r_b;

    assign w_add    = r_a + r_b;
    assign w_sub    = r_a - r_b;
    assign w_sh     = r_b[SHW-1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (op == c_OP_MUL || op == c_OP_MULHU)
                        w_state_nxt = c_ST_MUL;
                    else if ((op == c_OP_DIVU || op == c_OP_REMU) && i2 != '0)
                        w_state_nxt = c_ST_DIV;
                    else
                        w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_MUL, c_ST_DIV: begin
                if (w_last)
                    w_state_nxt = c_ST_DONE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= c_ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_dz  = 1'b0;
        w_bad = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                w_res = w_add;
                w_ovf = (r_a[c_MSB] == r_b[c_MSB]) && (w_add[c_MSB] != r_a[c_MSB]);
            end
            c_OP_SUB: begin
                w_res = w_sub;
                w_ovf = (r_a[c_MSB] != r_b[c_MSB]) && (w_sub[c_MSB] != r_a[c_MSB]);
            end
            c_OP_AND:   w_res = r_a & r_b;
            c_OP_OR:    w_res = r_a | r_b;
            c_OP_SLL:   w_res = r_a << w_sh;
            c_OP_SRL:   w_res = r_a >> w_sh;
            c_OP_SLT:   w_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            c_OP_NOR:   w_res = ~(r_a | r_b);
            c_OP_SRA:   w_res = WIDTH'($signed(r_a) >>> w_sh);
            c_OP_SLTU:  w_res = {{(WIDTH-1){1'b0}}, (r_a < r_b)};
            c_OP_MUL:   w_res = r_acc[WIDTH-1:0];
            c_OP_MULHU: w_res = r_acc[2*WIDTH-1:WIDTH];
            c_OP_DIVU: begin
                w_dz  = (r_b == '0);
                w_res = w_dz ? {WIDTH{1'b1}} : r_quo;
            end
            c_OP_REMU: begin
                w_dz  = (r_b == '0);
                w_res = w_dz ? r_a : r_rem;
            end
            default:    w_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_o1    <= '0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
            r_dz    <= 1'b0;
            r_bad   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_op  <= op;
                        r_a   <= i1;
                        r_b   <= i2;
                        r_cnt <= c_CNT_W'(WIDTH);
                        r_acc <= {{WIDTH{1'b0}}, i2};
                        r_rem <= '0;
                        r_quo <= i1;
                    end
                end
                c_ST_MUL: begin
                    r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
                c_ST_DIV: begin
                    r_rem <= w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
                default: begin
                    r_o1    <= w_res;
                    r_zero  <= (w_res == '0);
                    r_ovf   <= w_ovf;
                    r_dz    <= w_dz;
                    r_bad   <= w_bad;
                    r_valid <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed, table-driven self-checking bench for alu_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] i1;
    logic [WIDTH-1:0] i2;
    logic             out_valid;
    logic [WIDTH-1:0] o1;
    logic             zero;
    logic             ovf;
    logic             dz;
    logic             bad_op;

    int n_chk  = 0;
    int n_fail = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .i1        (i1),
        .i2        (i2),
        .out_valid (out_valid),
        .o1        (o1),
        .zero      (zero),
        .ovf       (ovf),
        .dz        (dz),
        .bad_op    (bad_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             ovf;
        logic             dz;
        logic             bad;
        int               lat;
        string            name;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] res, input logic eovf, input logic edz,
                           input logic ebad, input int lat, input string name);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.res = res;
        v.ovf = eovf; v.dz = edz; v.bad = ebad; v.lat = lat; v.name = name;
        tbl.push_back(v);
    endtask

    // Issue one request and check latency, busy behaviour, result and flags.
    task automatic run_vec(input vec_t v);
        int  lat;
        bit  busy_ready;
        lat = 0;
        while (!in_ready && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check({v.name, " ready"}, 32'(in_ready), 32'd1);
        op = v.op; i1 = v.a; i2 = v.b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        busy_ready = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (in_ready) busy_ready = 1'b1;
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
        end
        check({v.name, " latency"},  32'(lat), 32'(v.lat));
        check({v.name, " busy"},     32'(busy_ready), 32'd0);
        check({v.name, " o1"},       32'(o1), 32'(v.res));
        check({v.name, " zero"},     32'(zero), 32'(v.res == '0));
        check({v.name, " ovf"},      32'(ovf), 32'(v.ovf));
        check({v.name, " dz"},       32'(dz), 32'(v.dz));
        check({v.name, " bad_op"},   32'(bad_op), 32'(v.bad));
        @(posedge clk); #1;
        check({v.name, " pulse"},    32'(out_valid), 32'd0);
        check({v.name, " hold"},     32'(o1), 32'(v.res));
    endtask

    initial begin
        int lat;
        int extra;

        add_vec(4'h0, 16'h7FFF, 16'h0001, 16'h8000, 1, 0, 0, 1,  "add_ovf");
        add_vec(4'h1, 16'h1234, 16'h1234, 16'h0000, 0, 0, 0, 1,  "sub_zero");
        add_vec(4'h8, 16'h8000, 16'h0013, 16'hF000, 0, 0, 0, 1,  "sra");
        add_vec(4'h6, 16'hFFFF, 16'h0001, 16'h0001, 0, 0, 0, 1,  "slt");
        add_vec(4'h9, 16'hFFFF, 16'h0001, 16'h0000, 0, 0, 0, 1,  "sltu");
        add_vec(4'h2, 16'hF0F0, 16'h3C3C, 16'h3030, 0, 0, 0, 1,  "and");
        add_vec(4'h3, 16'hF0F0, 16'h3C3C, 16'hFCFC, 0, 0, 0, 1,  "or");
        add_vec(4'h7, 16'hF0F0, 16'h3C3C, 16'h0303, 0, 0, 0, 1,  "nor");
        add_vec(4'h4, 16'h0001, 16'h0014, 16'h0010, 0, 0, 0, 1,  "sll");
        add_vec(4'h5, 16'h8000, 16'hFFFF, 16'h0001, 0, 0, 0, 1,  "srl");
        add_vec(4'h1, 16'h8000, 16'h0001, 16'h7FFF, 1, 0, 0, 1,  "sub_ovf");
        add_vec(4'h0, 16'hFFFF, 16'h0001, 16'h0000, 0, 0, 0, 1,  "add_wrap");
        add_vec(4'hA, 16'h0123, 16'h0456, 16'hEDC2, 0, 0, 0, 17, "mul");
        add_vec(4'hB, 16'h0123, 16'h0456, 16'h0004, 0, 0, 0, 17, "mulhu");
        add_vec(4'hA, 16'hFFFF, 16'hFFFF, 16'h0001, 0, 0, 0, 17, "mul_max");
        add_vec(4'hB, 16'hFFFF, 16'hFFFF, 16'hFFFE, 0, 0, 0, 17, "mulhu_max");
        add_vec(4'hC, 16'd1000, 16'd7,    16'd142,  0, 0, 0, 17, "divu");
        add_vec(4'hD, 16'd1000, 16'd7,    16'd6,    0, 0, 0, 17, "remu");
        add_vec(4'hC, 16'hFFFF, 16'h0001, 16'hFFFF, 0, 0, 0, 17, "divu_one");
        add_vec(4'hC, 16'd5,    16'd0,    16'hFFFF, 0, 1, 0, 1,  "divu_dz");
        add_vec(4'hD, 16'd5,    16'd0,    16'd5,    0, 1, 0, 1,  "remu_dz");
        add_vec(4'hF, 16'h1234, 16'h5678, 16'h0000, 0, 0, 1, 1,  "bad_f");
        add_vec(4'hE, 16'h1234, 16'h5678, 16'h0000, 0, 0, 1, 1,  "bad_e");
        add_vec(4'hD, 16'd200,  16'd9,    16'd2,    0, 0, 0, 17, "remu_2");

        reset = 1'b1; in_valid = 1'b0; op = '0; i1 = '0; i2 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst in_ready",  32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst o1",        32'(o1), 32'd0);
        check("rst zero",      32'(zero), 32'd0);
        check("rst flags",     32'({ovf, dz, bad_op}), 32'd0);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Request held high across a busy multiply must be taken exactly once.
        op = 4'hA; i1 = 16'h0123; i2 = 16'h0456; in_valid = 1'b1;
        @(posedge clk); #1;
        op = 4'h0; i1 = 16'd2; i2 = 16'd3;
        lat = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
        end
        check("hold mul latency", 32'(lat), 32'd17);
        check("hold mul o1",      32'(o1), 32'h0000EDC2);
        @(posedge clk); #1;
        check("hold accept busy", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("hold add valid",   32'(out_valid), 32'd1);
        check("hold add o1",      32'(o1), 32'd5);
        extra = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        check("hold single accept", 32'(extra), 32'd0);

        // Reset in the middle of a multiply aborts it without a result.
        op = 4'hA; i1 = 16'h0123; i2 = 16'h0456; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort o1",        32'(o1), 32'd0);
        check("abort in_ready",  32'(in_ready), 32'd1);
        check("abort zero",      32'(zero), 32'd0);
        extra = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        check("abort no pulse", 32'(extra), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
